// File: rtl/step_sequencer_if.sv
// step_sequencer_if: control/status bundle between block-level control and
// the step sequencer. The master drives start/abort/cond; the slave (the
// sequencer) drives the status outputs.
interface step_sequencer_if #(
  parameter int unsigned NUM_STEPS = 4
);
  localparam int unsigned STEP_W = $clog2(NUM_STEPS);

  logic                 start;
  logic                 abort;
  logic [NUM_STEPS-1:0] cond;
  logic                 busy;
  logic [STEP_W-1:0]    step;
  logic                 done;
  logic                 err;
  logic [1:0]           state;

  modport master (
    output start, abort, cond,
    input  busy, step, done, err, state
  );

  modport slave (
    input  start, abort, cond,
    output busy, step, done, err, state
  );
endinterface

// File: rtl/step_sequencer.sv
// step_sequencer: walks NUM_STEPS ordered steps, leaving step i only when
// cond[i] is high. start/abort control, one-cycle done pulse, and an optional
// per-step watchdog with a sticky ERROR state, built when the macro
// STEP_SEQUENCER_TIMEOUT_EN is defined.
module step_sequencer #(
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  step_sequencer_if.slave       bus
);
  localparam int unsigned STEP_W = $clog2(NUM_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_e;

  // Reject out-of-range configurations at elaboration time.
  if (NUM_STEPS < 2 || NUM_STEPS > 256) begin : g_bad_num_steps
    $error("step_sequencer: NUM_STEPS out of range 2..256");
  end
  if (TIMEOUT < 2 || longint'(TIMEOUT) > ((longint'(1) << TIMEOUT_W) - 1)) begin : g_bad_timeout
    $error("step_sequencer: TIMEOUT out of range 2..2^TIMEOUT_W-1");
  end

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q,  step_d;
  logic              cond_hit;

  assign cond_hit = bus.cond[step_q];

`ifdef STEP_SEQUENCER_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT - 1);
  logic [TIMEOUT_W-1:0] timer_q, timer_d;

  // State, step index and step timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      timer_q <= timer_d;
    end
  end
`else
  // State and step index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end
`endif

  // Next-state logic: abort beats cond[step], cond[step] beats the watchdog.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
    timer_d = timer_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_RUN;
          step_d  = '0;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          step_d  = '0;
        end else if (cond_hit) begin
          if (step_q == LAST_STEP) begin
            state_d = S_DONE;
            step_d  = '0;
          end else begin
            step_d  = step_q + 1'b1;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
            timer_d = '0;
`endif
          end
        end else begin
`ifdef STEP_SEQUENCER_TIMEOUT_EN
          if (timer_q == TIMER_LAST) begin
            state_d = S_ERROR;
            step_d  = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = '0;
      end
    endcase
  end

  // Status outputs decode the registered state only.
  always_comb begin
    bus.busy  = (state_q == S_RUN);
    bus.done  = (state_q == S_DONE);
`ifdef STEP_SEQUENCER_TIMEOUT_EN
    bus.err   = (state_q == S_ERROR);
`else
    bus.err   = 1'b0;
`endif
    bus.step  = (state_q == S_RUN) ? step_q : '0;
    bus.state = state_q;
  end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: table-driven vectors, hand-written corner sequences and
// random stimulus checked against a cycle-count reference model.
module tb_step_sequencer;
  localparam int NS = 4;
  localparam int TO = 8;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  step_sequencer_if #(.NUM_STEPS(NS)) bus ();

  step_sequencer #(
    .NUM_STEPS(NS),
    .TIMEOUT  (TO),
    .TIMEOUT_W(TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state as 0..3, current step, cycles spent in the step.
  int m_state = 0;
  int m_step  = 0;
  int m_wait  = 0;

  typedef struct {
    logic       r;
    logic       s;
    logic       a;
    logic [3:0] c;
    int         st;
    int         sp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic a, input logic [NS-1:0] c);
    if (r) begin
      m_state = 0; m_step = 0; m_wait = 0;
    end else begin
      case (m_state)
        0: if (s && !a) begin m_state = 1; m_step = 0; m_wait = 0; end
        1: begin
          if (a) begin
            m_state = 0; m_step = 0;
          end else if (c[m_step]) begin
            if (m_step == NS - 1) begin m_state = 2; m_step = 0; end
            else begin m_step = m_step + 1; m_wait = 0; end
          end else begin
            m_wait = m_wait + 1;
`ifdef STEP_SEQUENCER_TIMEOUT_EN
            if (m_wait == TO) begin m_state = 3; m_step = 0; end
`endif
          end
        end
        2: m_state = 0;
        default: if (a) m_state = 0;
      endcase
    end
  endtask

  // One clock: apply inputs, advance model, compare every output 1 ns after the edge.
  task automatic cyc(input logic r, input logic s, input logic a, input logic [NS-1:0] c);
    rst       = r;
    bus.start = s;
    bus.abort = a;
    bus.cond  = c;
    @(posedge clk);
    model_edge(r, s, a, c);
    #1;
    chk("model_state", 32'(bus.state), m_state);
    chk("model_step",  32'(bus.step),  m_step);
    chk("model_busy",  32'(bus.busy),  (m_state == 1) ? 1 : 0);
    chk("model_done",  32'(bus.done),  (m_state == 2) ? 1 : 0);
    chk("model_err",   32'(bus.err),   (m_state == 3) ? 1 : 0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.cond = '0;

    // Reset hold, full run, DONE handling, start+abort, out-of-order conds.
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 4'hF, 0, 0});
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 4'hF, 0, 0});
    tbl.push_back(vec_t'{1'b1, 1'b1, 1'b0, 4'hF, 0, 0});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'h0, 0, 0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 4'h0, 1, 0});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'hF, 1, 1});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'hF, 1, 2});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'hF, 1, 3});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'hF, 2, 0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 4'hF, 0, 0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'h0, 0, 0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 4'h0, 1, 0});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'hE, 1, 0});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'h1, 1, 1});
    for (int k = 0; k < 5; k++) tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'hD, 1, 1});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'h2, 1, 2});
    tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 4'hF, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].c);
      chk("tbl_state", 32'(bus.state), tbl[i].st);
      chk("tbl_step",  32'(bus.step),  tbl[i].sp);
      chk("tbl_done",  32'(bus.done),  (tbl[i].st == 2) ? 1 : 0);
      chk("tbl_err",   32'(bus.err),   0);
    end

`ifdef STEP_SEQUENCER_TIMEOUT_EN
    // Timeout in step 2: still RUN after 7 idle cycles, ERROR after the 8th.
    cyc(0, 1, 0, 4'h0);
    cyc(0, 0, 0, 4'h1);
    cyc(0, 0, 0, 4'h2);
    chk("to_step2", 32'(bus.step), 2);
    for (int k = 0; k < 7; k++) begin
      cyc(0, 0, 0, 4'h0);
      chk("to_still_run", 32'(bus.state), 1);
    end
    cyc(0, 0, 0, 4'h0);
    chk("to_state", 32'(bus.state), 3);
    chk("to_err", 32'(bus.err), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 4'hF);
      chk("err_sticky", 32'(bus.state), 3);
    end
    cyc(0, 0, 1, 4'h0);
    chk("err_abort", 32'(bus.state), 0);

    // cond arriving in the 8th cycle of a step wins over the watchdog.
    cyc(0, 1, 0, 4'h0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 4'h0);
    cyc(0, 0, 0, 4'h1);
    chk("race_step", 32'(bus.step), 1);
    chk("race_err", 32'(bus.err), 0);
    cyc(0, 0, 0, 4'h2);
    cyc(0, 0, 0, 4'h4);
`else
    // Without the watchdog a step waits indefinitely.
    cyc(0, 1, 0, 4'h0);
    for (int k = 0; k < 300; k++) begin
      cyc(0, 0, 0, 4'h0);
      chk("nowd_busy", 32'(bus.busy), 1);
      chk("nowd_err", 32'(bus.err), 0);
      chk("nowd_state", 32'(bus.state), 1);
    end
    cyc(0, 0, 0, 4'h1);
    chk("nowd_step1", 32'(bus.step), 1);
    cyc(0, 0, 0, 4'h2);
    cyc(0, 0, 0, 4'h4);
`endif
    // abort together with cond[3] in the last step: back to IDLE, no done.
    chk("last_step", 32'(bus.step), 3);
    cyc(0, 0, 1, 4'h8);
    chk("abort_race_state", 32'(bus.state), 0);
    chk("abort_race_done", 32'(bus.done), 0);
    cyc(0, 0, 0, 4'h8);
    chk("abort_race_done2", 32'(bus.done), 0);

    // Random stimulus against the reference model.
    for (int k = 0; k < 4000; k++) begin
      logic r, s, a;
      logic [NS-1:0] c;
      r = ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 24) == 0);
      s = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
      cyc(r, s, a, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
